spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Round-robin arbiter that shares one `spi_mem` FRAM controller between `N_REQ` requesters. Each requester sees a private copy of the `spi_mem` en/valid level handshake. The arbiter serialises whole transactions onto the single downstream port and returns read data and completion to the granted requester only. It sits directly in front of `spi_mem`, with its `mem_*` ports wired to `spi_mem`'s user-side ports.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters, 2..8.
- `ADDR_W`, 6 — word address width, matches `spi_mem` `addr`.
- `DATA_W`, 8 — data width.
- `TIMEOUT_CYC`, 4096 — maximum cycles from `mem_en` rise to `mem_valid` before the transaction is aborted.

Ports:
- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_en`  in  `N_REQ`  — per-requester transaction request, level, held until that requester's `req_valid`.
- `req_wr_en`  in  `N_REQ`  — 1 = write, 0 = read; stable while `req_en` is high.
- `req_addr`  in  `N_REQ*ADDR_W`  — packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_wr_data`  in  `N_REQ*DATA_W`  — packed write data, same packing as `req_addr`.
- `req_valid`  out  `N_REQ`  — completion to the granted requester, one-hot or zero.
- `req_err`  out  1  — qualifies `req_valid`: 1 = transaction timed out.
- `req_rd_data`  out  `DATA_W`  — read data, shared by all requesters, meaningful only with `req_valid`.
- `mem_en`, `mem_wr_en`, `mem_addr`, `mem_wr_data`  out  1/1/`ADDR_W`/`DATA_W`  — to `spi_mem`.
- `mem_rd_data`  in  `DATA_W`  — from `spi_mem`.
- `mem_valid`  in  1  — from `spi_mem`.
- `timeout_seen`  out  1  — sticky timeout flag, cleared only by `rst`.

## Operation
- **FSM states:** IDLE, BUSY, DONE, RELEASE. Reset state is IDLE.
- **IDLE:** if any `req_en` bit is high, pick the winner by round-robin starting at `prio_ptr`. Register `grant` (one-hot), `mem_wr_en`, `mem_addr`, `mem_wr_data` from the winner's slices. Set `mem_en`=1. Go to BUSY.
- **BUSY:** hold `mem_en`=1 and hold all `mem_*` outputs stable; the timeout counter increments.
  - On `mem_valid`=1: capture `mem_rd_data` into `req_rd_data`, set `req_err`=0, go to DONE.
  - On counter == `TIMEOUT_CYC`-1: set `req_err`=1, set `timeout_seen`=1, drop `mem_en`, go to DONE.
- **DONE:** `req_valid` = `grant`. When the granted requester's `req_en` goes 0: drop `mem_en`, clear `req_valid`, go to RELEASE.
  - If the granted requester already dropped `req_en` before completion, `req_valid` is held for exactly one cycle and the result is discarded.
- **RELEASE:** wait for `mem_valid`=0. Then set `prio_ptr` = granted index + 1 (mod `N_REQ`), clear `grant`, go to IDLE. This guarantees `spi_mem` is back in its idle handshake state before the next grant.
- **Fairness:** a requester that keeps `req_en` high after its completion is re-arbitrated behind all others. Worst-case wait is (`N_REQ`-1) transactions.
- **Ignored inputs:**
  - `req_en` from non-granted requesters is ignored outside IDLE.
  - Changes to the granted requester's addr/data after grant are ignored, because they are latched at grant.
- **Reset:** `rst` anywhere, including mid-transaction, returns the FSM to IDLE and clears `prio_ptr`, counter, `grant`, and all outputs. `spi_mem` shares the same `rst`.

## Timing
Reset values:
- All outputs are 0: `mem_en`, `mem_wr_en`, `mem_addr`, `mem_wr_data`, `req_valid`, `req_err`, `req_rd_data`, `timeout_seen`.
- `prio_ptr` is 0.

Latency:
- `req_en` rising edge sampled in IDLE → `mem_en`=1 on the next cycle (1-cycle arbitration latency).
- `mem_valid`=1 sampled → `req_valid` high the next cycle (1 cycle).
- Granted `req_en` low sampled → `req_valid` and `mem_en` low the next cycle.
- Minimum spacing between two grants is the RELEASE duration plus 1 IDLE cycle.

Handshake and counter rules:
- All outputs are registered.
- `req_valid` never asserts while the corresponding `req_en` is low, except the single discard cycle.
- Timeout counter width is `$clog2(TIMEOUT_CYC)`. It is reset on each entry to BUSY and saturates, never wrapping.

## Structure
- **Package `spi_mem_arb_pkg`:**
  - state enum {IDLE, BUSY, DONE, RELEASE};
  - `IDX_W` = `$clog2(N_REQ)` helper function;
  - default parameter constants.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are the request vector and `prio_ptr`; outputs are the one-hot grant, the grant index, and `any`. It is instantiated once.
- **Top-level contents:** the FSM, the latch registers, and the timeout counter.

## Test plan
- **Single request:** requester 2 write, addr 0x15, data 0xA7 → `mem_en`=1 one cycle after `req_en`, with `mem_addr`=0x15 and `mem_wr_data`=0xA7. Only `req_valid[2]` rises, one cycle after `mem_valid`.
- **Simultaneous requests:** all 4 `req_en` high from reset → grants in order 0,1,2,3,0. No overlap of `req_valid` bits. `mem_en` low for at least 1 cycle between grants.
- **Read return:** the `spi_mem` model returns 0x3C for requester 1 reading addr 0x2A → `req_rd_data`=0x3C with `req_valid[1]`=1 and `req_err`=0.
- **Timeout:** `TIMEOUT_CYC`=16 and the model never asserts `mem_valid` → `req_valid` with `req_err`=1 at cycle 17 after grant. `timeout_seen` stays 1 until `rst`.
- **Reset mid-operation:** assert `rst` in BUSY → all outputs 0 the next cycle. After release, a pending `req_en[3]` is granted first only if it is the lowest index ≥ 0 that is requesting.
- **Early drop:** requester drops `req_en` during BUSY → transaction completes downstream, a 1-cycle `req_valid`, then RELEASE, with no hang.

Source files
------------

// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types and defaults for the spi_mem round-robin arbiter.
package spi_mem_arb_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    RELEASE
  } arb_state_e;

  // Index width, kept at least one bit wide so N_REQ=1 corner still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i.
module rr_pick
  import spi_mem_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_w(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   off;
  logic [IDX_W:0]   sum;

  // Rotate so ptr_i lands on bit 0, find the first set bit, then rotate back.
  always_comb begin
    rot   = N_REQ'({req_i, req_i} >> ptr_i);
    off   = '0;
    any_o = |req_i;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = (IDX_W+1)'(j);
    end
    sum = {1'b0, ptr_i} + off;
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    idx_o   = sum[IDX_W-1:0];
    grant_o = any_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one spi_mem controller between N_REQ requesters, one whole transaction at a time.
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_en,
  input  logic [N_REQ-1:0]         req_wr_en,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wr_data,
  output logic [N_REQ-1:0]         req_valid,
  output logic                     req_err,
  output logic [DATA_W-1:0]        req_rd_data,
  output logic                     mem_en,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  input  logic [DATA_W-1:0]        mem_rd_data,
  input  logic                     mem_valid,
  output logic                     timeout_seen
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  prio_q;
  logic [IDX_W-1:0]  prio_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              mem_en_q;
  logic              mem_wr_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic [N_REQ-1:0]  req_valid_q;
  logic              req_err_q;
  logic [DATA_W-1:0] req_rd_data_q;
  logic              timeout_q;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_en),
    .ptr_i   (prio_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Counter saturates at all-ones; the granted requester moves to the back of the ring.
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign prio_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      idx_q         <= '0;
      prio_q        <= '0;
      cnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      req_valid_q   <= '0;
      req_err_q     <= 1'b0;
      req_rd_data_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q       <= pick_grant;
            idx_q         <= pick_idx;
            mem_wr_en_q   <= req_wr_en[pick_idx];
            mem_addr_q    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wr_data_q <= req_wr_data[pick_idx*DATA_W +: DATA_W];
            mem_en_q      <= 1'b1;
            cnt_q         <= '0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_d;
          if (mem_valid) begin
            req_rd_data_q <= mem_rd_data;
            req_err_q     <= 1'b0;
            req_valid_q   <= grant_q;
            state_q       <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            req_err_q   <= 1'b1;
            timeout_q   <= 1'b1;
            mem_en_q    <= 1'b0;
            req_valid_q <= grant_q;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (!req_en[idx_q]) begin
            req_valid_q <= '0;
            mem_en_q    <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!mem_valid) begin
            prio_q  <= prio_d;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_valid    = req_valid_q;
  assign req_err      = req_err_q;
  assign req_rd_data  = req_rd_data_q;
  assign mem_en       = mem_en_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign timeout_seen = timeout_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a hand-driven spi_mem handshake.
module tb_spi_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_en;
  logic [N-1:0]  req_wr_en;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]  req_valid;
  logic          req_err;
  logic [DW-1:0] req_rd_data;
  logic          mem_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          mem_valid;
  logic          timeout_seen;

  int checks;
  int errors;

  spi_mem_arbiter #(
    .N_REQ       (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_en       (req_en),
    .req_wr_en    (req_wr_en),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .req_valid    (req_valid),
    .req_err      (req_err),
    .req_rd_data  (req_rd_data),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_valid    (mem_valid),
    .timeout_seen (timeout_seen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic en, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_en[i]              = en;
    req_wr_en[i]           = wr;
    req_addr[i*AW +: AW]   = addr;
    req_wr_data[i*DW +: DW] = data;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_en"},   32'(mem_en), 0);
    checkOutput({tag, "_mem_wr"},   32'(mem_wr_en), 0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 0);
    checkOutput({tag, "_mem_wd"},   32'(mem_wr_data), 0);
    checkOutput({tag, "_valid"},    32'(req_valid), 0);
    checkOutput({tag, "_err"},      32'(req_err), 0);
    checkOutput({tag, "_rd"},       32'(req_rd_data), 0);
    checkOutput({tag, "_tos"},      32'(timeout_seen), 0);
  endtask

  initial begin
    logic [N-1:0] expV;
    int g;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    req_en      = '0;
    req_wr_en   = '0;
    req_addr    = '0;
    req_wr_data = '0;
    mem_rd_data = '0;
    mem_valid   = 1'b0;

    step();
    step();
    checkAllZero("reset");
    rst = 1'b0;
    step();

    $display("[TB] single write from requester 2");
    applyStimulus(2, 1'b1, 1'b1, 6'h15, 8'hA7);
    checkOutput("w_pre_mem_en", 32'(mem_en), 0);
    step();
    checkOutput("w_mem_en", 32'(mem_en), 1);
    checkOutput("w_mem_wr", 32'(mem_wr_en), 1);
    checkOutput("w_mem_addr", 32'(mem_addr), 'h15);
    checkOutput("w_mem_wd", 32'(mem_wr_data), 'hA7);
    checkOutput("w_busy_valid", 32'(req_valid), 0);
    applyStimulus(2, 1'b1, 1'b1, 6'h3F, 8'h11);
    step();
    checkOutput("w_latched_addr", 32'(mem_addr), 'h15);
    checkOutput("w_latched_wd", 32'(mem_wr_data), 'hA7);
    checkOutput("w_busy_mem_en", 32'(mem_en), 1);
    mem_valid = 1'b1;
    step();
    checkOutput("w_valid", 32'(req_valid), 'b0100);
    checkOutput("w_err", 32'(req_err), 0);
    req_en[2] = 1'b0;
    step();
    checkOutput("w_rel_valid", 32'(req_valid), 0);
    checkOutput("w_rel_mem_en", 32'(mem_en), 0);
    mem_valid = 1'b0;
    step();

    $display("[TB] all four requesting from reset");
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 1'b0, 6'(6'h10 + i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      step();
      checkOutput("rr_mem_en", 32'(mem_en), 1);
      checkOutput("rr_mem_addr", 32'(mem_addr), 32'(6'h10 + g));
      mem_valid   = 1'b1;
      mem_rd_data = 8'(8'h50 + g);
      step();
      expV = 4'b0001 << g;
      checkOutput("rr_valid", 32'(req_valid), 32'(expV));
      checkOutput("rr_rd", 32'(req_rd_data), 32'(8'h50 + g));
      req_en[g] = 1'b0;
      mem_valid = 1'b0;
      step();
      checkOutput("rr_rel_valid", 32'(req_valid), 0);
      checkOutput("rr_rel_mem_en", 32'(mem_en), 0);
      req_en[g] = 1'b1;
      step();
      checkOutput("rr_gap_mem_en", 32'(mem_en), 0);
    end

    $display("[TB] read return for requester 1");
    req_en = '0;
    applyStimulus(1, 1'b1, 1'b0, 6'h2A, 8'h00);
    step();
    checkOutput("rd_mem_en", 32'(mem_en), 1);
    checkOutput("rd_mem_wr", 32'(mem_wr_en), 0);
    checkOutput("rd_mem_addr", 32'(mem_addr), 'h2A);
    mem_valid   = 1'b1;
    mem_rd_data = 8'h3C;
    step();
    checkOutput("rd_valid", 32'(req_valid), 'b0010);
    checkOutput("rd_data", 32'(req_rd_data), 'h3C);
    checkOutput("rd_err", 32'(req_err), 0);
    req_en[1] = 1'b0;
    mem_valid = 1'b0;
    step();
    step();

    $display("[TB] timeout on requester 0");
    applyStimulus(0, 1'b1, 1'b0, 6'h05, 8'h00);
    step();
    checkOutput("to_mem_en", 32'(mem_en), 1);
    for (int k = 1; k < TO; k++) step();
    checkOutput("to_pre_valid", 32'(req_valid), 0);
    checkOutput("to_pre_mem_en", 32'(mem_en), 1);
    checkOutput("to_pre_tos", 32'(timeout_seen), 0);
    step();
    checkOutput("to_valid", 32'(req_valid), 'b0001);
    checkOutput("to_err", 32'(req_err), 1);
    checkOutput("to_tos", 32'(timeout_seen), 1);
    checkOutput("to_mem_en_drop", 32'(mem_en), 0);
    req_en[0] = 1'b0;
    step();
    step();
    checkOutput("to_after_valid", 32'(req_valid), 0);
    checkOutput("to_sticky", 32'(timeout_seen), 1);

    $display("[TB] reset in BUSY");
    applyStimulus(1, 1'b0, 1'b0, 6'h21, 8'h00);
    applyStimulus(3, 1'b1, 1'b1, 6'h33, 8'hC3);
    step();
    checkOutput("mr_mem_en", 32'(mem_en), 1);
    checkOutput("mr_mem_addr", 32'(mem_addr), 'h33);
    checkOutput("mr_mem_wd", 32'(mem_wr_data), 'hC3);
    step();
    rst       = 1'b1;
    req_en[1] = 1'b1;
    step();
    checkAllZero("mr");
    rst = 1'b0;
    step();
    checkOutput("mr_regrant_en", 32'(mem_en), 1);
    checkOutput("mr_regrant_addr", 32'(mem_addr), 'h21);
    mem_valid   = 1'b1;
    mem_rd_data = 8'h99;
    step();
    checkOutput("mr_regrant_valid", 32'(req_valid), 'b0010);
    req_en[1] = 1'b0;
    mem_valid = 1'b0;
    step();
    step();
    step();
    checkOutput("ed_mem_en", 32'(mem_en), 1);
    checkOutput("ed_mem_addr", 32'(mem_addr), 'h33);

    $display("[TB] early drop by requester 3");
    req_en[3] = 1'b0;
    step();
    checkOutput("ed_busy_valid", 32'(req_valid), 0);
    mem_valid = 1'b1;
    step();
    checkOutput("ed_discard_valid", 32'(req_valid), 'b1000);
    step();
    checkOutput("ed_valid_one_cycle", 32'(req_valid), 0);
    checkOutput("ed_rel_mem_en", 32'(mem_en), 0);
    step();
    checkOutput("ed_hold_mem_en", 32'(mem_en), 0);
    mem_valid = 1'b0;
    step();
    applyStimulus(0, 1'b1, 1'b0, 6'h07, 8'h00);
    step();
    checkOutput("ed_next_mem_en", 32'(mem_en), 1);
    checkOutput("ed_next_addr", 32'(mem_addr), 'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
